// File: rtl/completion_regfile.sv
// Architectural register file with per-register producer tag table.
// Snoops the adder, multiplier and load result buses and renames destinations on dispatch.
module completion_regfile #(
    parameter int                DATA_W    = 32,
    parameter int                TAG_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [39:0]       instbus1,
    input  logic [39:0]       instbus2,
    input  logic [39:0]       addbus,
    input  logic [39:0]       multbus,
    input  logic [39:0]       loadbus,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3,
    output logic [TAG_W-1:0]  tag0,
    output logic [TAG_W-1:0]  tag1,
    output logic [TAG_W-1:0]  tag2,
    output logic [TAG_W-1:0]  tag3,
    output logic [15:0]       cmpl_cnt,
    output logic              quiet
);

    localparam logic [7:0]       OP_LOAD  = 8'h01;
    localparam logic [7:0]       OP_ADD   = 8'h03;
    localparam logic [7:0]       OP_MULTI = 8'h04;
    localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

    function automatic logic is_prod_tag(input logic [TAG_W-1:0] t);
        case (t)
            TAG_W'(8'h20), TAG_W'(8'h21), TAG_W'(8'h22),
            TAG_W'(8'h30), TAG_W'(8'h31),
            TAG_W'(8'h40), TAG_W'(8'h41): is_prod_tag = 1'b1;
            default:                      is_prod_tag = 1'b0;
        endcase
    endfunction

    // A dispatch slot renames only for a register-writing op, an R0..R3 dest and a real producer tag.
    function automatic logic rename_ok(input logic [39:0] ib);
        logic op_ok;
        logic dest_ok;
        case (ib[31:24])
            OP_LOAD, OP_ADD, OP_MULTI: op_ok = 1'b1;
            default:                   op_ok = 1'b0;
        endcase
        case (ib[7:0])
            8'h10, 8'h11, 8'h12, 8'h13: dest_ok = 1'b1;
            default:                    dest_ok = 1'b0;
        endcase
        rename_ok = op_ok && dest_ok && is_prod_tag(TAG_W'(ib[39:32]));
    endfunction

    function automatic logic [2:0] count_hits(input logic [3:0] h);
        count_hits = {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
    endfunction

    logic [DATA_W-1:0] reg_q [4];
    logic [DATA_W-1:0] reg_d [4];
    logic [TAG_W-1:0]  tag_q [4];
    logic [TAG_W-1:0]  tag_d [4];
    logic [15:0]       cmpl_cnt_q;
    logic [15:0]       cmpl_cnt_d;
    logic [3:0]        wb_hit_s;

    logic [TAG_W-1:0]  add_tag_s, mult_tag_s, load_tag_s;
    logic [DATA_W-1:0] add_data_s, mult_data_s, load_data_s;
    logic              add_ok_s, mult_ok_s, load_ok_s;
    logic              ren1_ok_s, ren2_ok_s;
    logic [1:0]        dest1_s, dest2_s;
    logic [TAG_W-1:0]  stn1_s, stn2_s;

    assign add_tag_s   = TAG_W'(addbus[39:32]);
    assign mult_tag_s  = TAG_W'(multbus[39:32]);
    assign load_tag_s  = TAG_W'(loadbus[39:32]);
    assign add_data_s  = DATA_W'(addbus[31:0]);
    assign mult_data_s = DATA_W'(multbus[31:0]);
    assign load_data_s = DATA_W'(loadbus[31:0]);
    assign add_ok_s    = is_prod_tag(add_tag_s);
    assign mult_ok_s   = is_prod_tag(mult_tag_s);
    assign load_ok_s   = is_prod_tag(load_tag_s);
    assign ren1_ok_s   = rename_ok(instbus1);
    assign ren2_ok_s   = rename_ok(instbus2);
    assign dest1_s     = instbus1[1:0];
    assign dest2_s     = instbus2[1:0];
    assign stn1_s      = TAG_W'(instbus1[39:32]);
    assign stn2_s      = TAG_W'(instbus2[39:32]);

    // Next-state: bus writeback by priority, then rename overrides the tag (slot 2 newest).
    always_comb begin
        wb_hit_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            reg_d[n] = reg_q[n];
            tag_d[n] = tag_q[n];
            if (tag_q[n] != TAG_NONE && add_ok_s && tag_q[n] == add_tag_s) begin
                reg_d[n]    = add_data_s;
                wb_hit_s[n] = 1'b1;
            end else if (tag_q[n] != TAG_NONE && mult_ok_s && tag_q[n] == mult_tag_s) begin
                reg_d[n]    = mult_data_s;
                wb_hit_s[n] = 1'b1;
            end else if (tag_q[n] != TAG_NONE && load_ok_s && tag_q[n] == load_tag_s) begin
                reg_d[n]    = load_data_s;
                wb_hit_s[n] = 1'b1;
            end else begin
                reg_d[n]    = reg_q[n];
                wb_hit_s[n] = 1'b0;
            end
            if (ren2_ok_s && dest2_s == 2'(n)) begin
                tag_d[n] = stn2_s;
            end else if (ren1_ok_s && dest1_s == 2'(n)) begin
                tag_d[n] = stn1_s;
            end else if (wb_hit_s[n]) begin
                tag_d[n] = TAG_NONE;
            end else begin
                tag_d[n] = tag_q[n];
            end
        end
        cmpl_cnt_d = cmpl_cnt_q + {13'd0, count_hits(wb_hit_s)};
    end

    // State registers; reset discards every pending producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                reg_q[n] <= RESET_VAL;
                tag_q[n] <= TAG_NONE;
            end
            cmpl_cnt_q <= 16'h0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                reg_q[n] <= reg_d[n];
                tag_q[n] <= tag_d[n];
            end
            cmpl_cnt_q <= cmpl_cnt_d;
        end
    end

    assign reg0     = reg_q[0];
    assign reg1     = reg_q[1];
    assign reg2     = reg_q[2];
    assign reg3     = reg_q[3];
    assign tag0     = tag_q[0];
    assign tag1     = tag_q[1];
    assign tag2     = tag_q[2];
    assign tag3     = tag_q[3];
    assign cmpl_cnt = cmpl_cnt_q;
    assign quiet    = (tag_q[0] == TAG_NONE) && (tag_q[1] == TAG_NONE) &&
                      (tag_q[2] == TAG_NONE) && (tag_q[3] == TAG_NONE);

endmodule

// File: tb/tb_completion_regfile.sv
// Scoreboard bench for completion_regfile: directed vectors push expected state, a negedge monitor checks it.
module tb_completion_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] instbus1, instbus2, addbus, multbus, loadbus;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [7:0]  tag0, tag1, tag2, tag3;
    logic [15:0] cmpl_cnt;
    logic        quiet;

    completion_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .instbus1(instbus1), .instbus2(instbus2),
        .addbus(addbus), .multbus(multbus), .loadbus(loadbus),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .tag0(tag0), .tag1(tag1), .tag2(tag2), .tag3(tag3),
        .cmpl_cnt(cmpl_cnt), .quiet(quiet)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        string        name;
        logic [127:0] regs;
        logic [31:0]  tags;
        logic [15:0]  cnt;
        logic         quiet;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic bad;

    localparam logic [39:0] IDLE = 40'h00_0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] ins(input logic [7:0] stn, input logic [7:0] op, input logic [7:0] dest);
        return {stn, op, 8'h00, 8'h00, dest};
    endfunction

    function automatic logic [39:0] bus(input logic [7:0] tag, input logic [31:0] data);
        return {tag, data};
    endfunction

    task automatic drive(input logic [39:0] i1, input logic [39:0] i2,
                         input logic [39:0] ab, input logic [39:0] mb, input logic [39:0] lb);
        @(posedge clk);
        #1;
        instbus1 = i1; instbus2 = i2; addbus = ab; multbus = mb; loadbus = lb;
    endtask

    task automatic expect_state(input string name,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] r3,
                                input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input logic [7:0] t3,
                                input logic [15:0] cnt);
        exp_t e;
        e.due   = cyc + 1;
        e.name  = name;
        e.regs  = {r3, r2, r1, r0};
        e.tags  = {t3, t2, t1, t0};
        e.cnt   = cnt;
        e.quiet = ({t3, t2, t1, t0} == 32'h0);
        q.push_back(e);
    endtask

    // Monitor: compare the registered state against the expectation due this cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            n_vec = n_vec + 1;
            bad = 1'b0;
            if (mon_e.due != cyc) begin
                $display("FAIL %s stale: checked at cycle %0d, required %0d", mon_e.name, cyc, mon_e.due);
                bad = 1'b1;
            end
            if ({reg3, reg2, reg1, reg0} !== mon_e.regs) begin
                $display("FAIL %s regs got %h required %h", mon_e.name, {reg3, reg2, reg1, reg0}, mon_e.regs);
                bad = 1'b1;
            end
            if ({tag3, tag2, tag1, tag0} !== mon_e.tags) begin
                $display("FAIL %s tags got %h required %h", mon_e.name, {tag3, tag2, tag1, tag0}, mon_e.tags);
                bad = 1'b1;
            end
            if (cmpl_cnt !== mon_e.cnt) begin
                $display("FAIL %s cmpl_cnt got %h required %h", mon_e.name, cmpl_cnt, mon_e.cnt);
                bad = 1'b1;
            end
            if (quiet !== mon_e.quiet) begin
                $display("FAIL %s quiet got %b required %b", mon_e.name, quiet, mon_e.quiet);
                bad = 1'b1;
            end
            if (bad) n_miss = n_miss + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instbus1 = IDLE; instbus2 = IDLE; addbus = IDLE; multbus = IDLE; loadbus = IDLE;

        drive(IDLE, IDLE, IDLE, IDLE, IDLE);
        expect_state("reset", 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        drive(IDLE, IDLE, IDLE, IDLE, IDLE);
        rst_n = 1'b1;
        expect_state("reset_release", 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);

        drive({8'h20, 8'h03, 8'h10, 8'h11, 8'h12}, IDLE, IDLE, IDLE, IDLE);
        expect_state("add_rename", 0, 0, 0, 0, 8'h00, 8'h00, 8'h20, 8'h00, 16'h0000);
        drive(IDLE, IDLE, bus(8'h20, 32'h5), IDLE, IDLE);
        expect_state("add_wb", 0, 0, 32'h5, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001);

        drive(ins(8'h20, 8'h03, 8'h11), ins(8'h30, 8'h04, 8'h11), IDLE, IDLE, IDLE);
        expect_state("slot2_wins", 0, 0, 32'h5, 0, 8'h00, 8'h30, 8'h00, 8'h00, 16'h0001);
        drive(IDLE, IDLE, bus(8'h20, 32'h7), IDLE, IDLE);
        expect_state("stale_drop", 0, 0, 32'h5, 0, 8'h00, 8'h30, 8'h00, 8'h00, 16'h0001);
        drive(IDLE, IDLE, IDLE, bus(8'h30, 32'h9), IDLE);
        expect_state("mult_wb", 0, 32'h9, 32'h5, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0002);

        drive(ins(8'h21, 8'h03, 8'h10), IDLE, IDLE, IDLE, IDLE);
        expect_state("r0_a1", 0, 32'h9, 32'h5, 0, 8'h21, 8'h00, 8'h00, 8'h00, 16'h0002);
        drive(ins(8'h40, 8'h01, 8'h10), IDLE, bus(8'h21, 32'h3), IDLE, IDLE);
        expect_state("wb_and_rename", 32'h3, 32'h9, 32'h5, 0, 8'h40, 8'h00, 8'h00, 8'h00, 16'h0003);

        drive(ins(8'h31, 8'h04, 8'h10), ins(8'h40, 8'h01, 8'h13), IDLE, IDLE, IDLE);
        expect_state("two_pending", 32'h3, 32'h9, 32'h5, 0, 8'h31, 8'h00, 8'h00, 8'h40, 16'h0003);
        drive(IDLE, IDLE, IDLE, bus(8'h31, 32'hA), bus(8'h40, 32'hB));
        expect_state("dual_wb", 32'hA, 32'h9, 32'h5, 32'hB, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0005);

        drive(ins(8'h22, 8'h03, 8'h11), IDLE, IDLE, IDLE, IDLE);
        expect_state("prio_rename", 32'hA, 32'h9, 32'h5, 32'hB, 8'h00, 8'h22, 8'h00, 8'h00, 16'h0005);
        drive(IDLE, IDLE, bus(8'h22, 32'h11), bus(8'h22, 32'h22), bus(8'h22, 32'h33));
        expect_state("bus_priority", 32'hA, 32'h11, 32'h5, 32'hB, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0006);

        drive(ins(8'h50, 8'h03, 8'h12), ins(8'h20, 8'h02, 8'h12), IDLE, IDLE, IDLE);
        expect_state("bad_stn_store", 32'hA, 32'h11, 32'h5, 32'hB, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0006);
        drive(ins(8'h20, 8'h03, 8'h14), ins(8'h20, 8'h05, 8'h13), IDLE, IDLE, IDLE);
        expect_state("bad_dest_op", 32'hA, 32'h11, 32'h5, 32'hB, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0006);

        drive(ins(8'h20, 8'h03, 8'h12), IDLE, bus(8'h20, 32'h77), IDLE, IDLE);
        expect_state("no_forward", 32'hA, 32'h11, 32'h5, 32'hB, 8'h00, 8'h00, 8'h20, 8'h00, 16'h0006);
        drive(IDLE, IDLE, bus(8'h20, 32'h55), IDLE, IDLE);
        expect_state("late_wb", 32'hA, 32'h11, 32'h55, 32'hB, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0007);

        drive(ins(8'h21, 8'h03, 8'h10), ins(8'h21, 8'h01, 8'h13), IDLE, IDLE, IDLE);
        expect_state("shared_tag", 32'hA, 32'h11, 32'h55, 32'hB, 8'h21, 8'h00, 8'h00, 8'h21, 16'h0007);
        drive(IDLE, IDLE, bus(8'h21, 32'hC), IDLE, IDLE);
        expect_state("shared_wb", 32'hC, 32'h11, 32'h55, 32'hC, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0009);

        // Two writebacks per cycle with continuous re-rename walk the counter up to FFFF.
        drive(ins(8'h20, 8'h03, 8'h10), ins(8'h30, 8'h04, 8'h11), IDLE, IDLE, IDLE);
        expect_state("loop_setup", 32'hC, 32'h11, 32'h55, 32'hC, 8'h20, 8'h30, 8'h00, 8'h00, 16'h0009);
        for (int i = 0; i < 32762; i++) begin
            drive(ins(8'h20, 8'h03, 8'h10), ins(8'h30, 8'h04, 8'h11),
                  bus(8'h20, i), bus(8'h30, ~i), IDLE);
        end
        drive(ins(8'h20, 8'h03, 8'h10), ins(8'h30, 8'h04, 8'h11),
              bus(8'h20, 32'hAAAA0001), bus(8'h30, 32'hBBBB0002), IDLE);
        expect_state("cnt_ffff", 32'hAAAA0001, 32'hBBBB0002, 32'h55, 32'hC,
                     8'h20, 8'h30, 8'h00, 8'h00, 16'hFFFF);
        drive(IDLE, IDLE, bus(8'h20, 32'h1234), IDLE, IDLE);
        expect_state("cnt_wrap", 32'h1234, 32'hBBBB0002, 32'h55, 32'hC,
                     8'h00, 8'h30, 8'h00, 8'h00, 16'h0000);

        drive(ins(8'h41, 8'h01, 8'h12), IDLE, IDLE, IDLE, IDLE);
        expect_state("pre_reset", 32'h1234, 32'hBBBB0002, 32'h55, 32'hC,
                     8'h00, 8'h30, 8'h41, 8'h00, 16'h0000);
        drive(IDLE, IDLE, IDLE, IDLE, IDLE);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        expect_state("mid_reset", 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        drive(IDLE, IDLE, IDLE, IDLE, IDLE);
        drive(IDLE, IDLE, IDLE, IDLE, IDLE);
        rst_n = 1'b1;
        drive(IDLE, IDLE, IDLE, bus(8'h30, 32'h99), bus(8'h41, 32'h98));
        expect_state("old_tag_ignored", 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        drive(IDLE, IDLE, IDLE, IDLE, IDLE);

        for (int k = 0; k < 8 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
            n_miss = n_miss + 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
